sm_seq_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-phase output sequence (ST0→ST1→ST2/ST3→ST3) among several requesters. Each grant runs exactly one complete pass of the sequence on `y`. The winning requester's `mode` bit steers the ST1 branch: 1 skips ST2. The block sits in front of the FSM datapath and owns its `control` selection and pass timing, so requesters never drive the sequence directly.

---
 rtl/sm_seq_arb.sv | 85 ++++++++
 tb/tb_sm_seq_arb.sv | 114 +++++++++++
 2 files changed

// File: rtl/sm_seq_arb.sv
// sm_seq_arb: round-robin arbiter driving a shared 4-phase Moore sequence, one pass per grant.
// Optional completed-pass counter on pass_cnt when SM_SEQ_ARB_STATS_EN is defined.
module sm_seq_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mode,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         y,
  output logic               busy,
  output logic               done
`ifdef SM_SEQ_ARB_STATS_EN
  ,
  output logic [15:0]        pass_cnt
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, ST0, ST1, ST2, ST3} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0] ptr_q, ptr_d, win;
  logic [PW:0] idx;
  logic mode_q, mode_d, found, arb;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      idx = idx >= (PW+1)'(NUM_REQ) ? idx - (PW+1)'(NUM_REQ) : idx;
      if (!found && req[idx]) begin
        found = 1'b1;
        win = idx[PW-1:0];
      end
    end
  end
  assign arb = enable && found;
  always_comb begin
    state_d = IDLE;
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    mode_d = mode_q;
    case (state_q)
      IDLE, ST3: begin
        state_d = arb ? ST0 : IDLE;
        gnt_d = arb ? {{(NUM_REQ-1){1'b0}}, 1'b1} << win : '0;
        ptr_d = !arb ? ptr_q : win == PW'(NUM_REQ-1) ? '0 : win + 1'b1;
        mode_d = arb ? mode[win] : mode_q;
      end
      ST0: state_d = ST1;
      ST1: state_d = mode_q ? ST3 : ST2;
      ST2: state_d = ST3;
      default: gnt_d = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      ptr_q <= '0;
      mode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      mode_q <= mode_d;
    end
  end
  assign gnt = gnt_q;
  assign y = state_q == ST1 ? 2'd1 : state_q == ST2 ? 2'd2 : state_q == ST3 ? 2'd3 : 2'd0;
  assign busy = state_q == ST0 || state_q == ST1 || state_q == ST2 || state_q == ST3;
  assign done = state_q == ST3;
`ifdef SM_SEQ_ARB_STATS_EN
  logic [15:0] pass_cnt_q, pass_cnt_d;
  always_comb pass_cnt_d = pass_cnt_q + {15'd0, done};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pass_cnt_q <= '0;
    else pass_cnt_q <= pass_cnt_d;
  end
  assign pass_cnt = pass_cnt_q;
`endif
endmodule

// File: tb/tb_sm_seq_arb.sv
// tb_sm_seq_arb: directed checks of sm_seq_arb passes, round-robin order, enable and reset.
// Define SM_SEQ_ARB_STATS_EN for both files to also exercise pass_cnt.
module tb_sm_seq_arb;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] mode = '0;
  logic enable = 1'b1;
  logic [3:0] gnt;
  logic [1:0] y;
  logic busy, done;
  logic [15:0] exp_cnt = '0;
  int n_cmp = 0;
  int n_err = 0;
`ifdef SM_SEQ_ARB_STATS_EN
  logic [15:0] pass_cnt;
`endif
  sm_seq_arb #(.NUM_REQ(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .mode(mode), .enable(enable),
    .gnt(gnt), .y(y), .busy(busy), .done(done)
`ifdef SM_SEQ_ARB_STATS_EN
    , .pass_cnt(pass_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, want, $time);
    end
  endtask
  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, " gnt"}, 32'(gnt), 0);
    chk({tag, " y"}, 32'(y), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
`ifdef SM_SEQ_ARB_STATS_EN
    chk({tag, " pass_cnt"}, 32'(pass_cnt), 32'(exp_cnt));
`endif
  endtask
  task automatic run_pass(input string tag, input logic [3:0] g, input logic m, input bit clr, input int dis_at);
    int len;
    len = m ? 3 : 4;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      chk($sformatf("%s gnt[%0d]", tag, i), 32'(gnt), 32'(g));
      chk($sformatf("%s y[%0d]", tag, i), 32'(y), (m && i == 2) ? 3 : i);
      chk($sformatf("%s busy[%0d]", tag, i), 32'(busy), 1);
      chk($sformatf("%s done[%0d]", tag, i), 32'(done), 32'(i == len - 1));
`ifdef SM_SEQ_ARB_STATS_EN
      chk($sformatf("%s pass_cnt[%0d]", tag, i), 32'(pass_cnt), 32'(exp_cnt));
`endif
      if (i == len - 1) exp_cnt++;
      if (clr && i == 0) begin
        req = '0;
        mode = '0;
      end
      if (i == dis_at) enable = 1'b0;
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst gnt", 32'(gnt), 0);
    chk("rst busy", 32'(busy), 0);
    reset_n = 1'b1;
    idle_chk("post_rst");
    idle_chk("post_rst2");
    req = 4'b0001;
    run_pass("m0", 4'b0001, 1'b0, 1'b1, -1);
    idle_chk("m0_end");
    req = 4'b0100;
    mode = 4'b0100;
    run_pass("m1", 4'b0100, 1'b1, 1'b1, -1);
    idle_chk("m1_end");
    req = 4'b0001;
    @(negedge clk);
    chk("mid ST0 gnt", 32'(gnt), 32'(4'b0001));
    req = '0;
    @(negedge clk);
    chk("mid ST1 y", 32'(y), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async gnt", 32'(gnt), 0);
    chk("async y", 32'(y), 0);
    chk("async busy", 32'(busy), 0);
    chk("async done", 32'(done), 0);
    exp_cnt = '0;
    req = 4'b1111;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) run_pass($sformatf("rr%0d", k), 4'(1 << k), 1'b0, 1'b0, -1);
    req = 4'b0011;
    run_pass("rr4", 4'b0001, 1'b0, 1'b0, 1);
    for (int k = 0; k < 3; k++) idle_chk($sformatf("en_off%0d", k));
    enable = 1'b1;
    run_pass("en_on", 4'b0010, 1'b0, 1'b1, -1);
    idle_chk("en_end");
`ifdef SM_SEQ_ARB_STATS_EN
    chk("stats six", 32'(pass_cnt), 6);
    force dut.pass_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.pass_cnt_q;
    exp_cnt = 16'hFFFF;
    req = 4'b0001;
    run_pass("wrap", 4'b0001, 1'b0, 1'b1, -1);
    idle_chk("wrap_end");
    chk("wrap zero", 32'(pass_cnt), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
